// File: rtl/mem_bus_arbiter.sv
// Shared-memory bus controller: serialises NUM_MASTERS req/ack requesters onto one memory port.
// Round-robin by default; define MEM_BUS_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_wen,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_bus_arbiter: WAIT_CYCLES=%0d is illegal (1..15)", WAIT_CYCLES);
  end
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
    $error("mem_bus_arbiter: NUM_MASTERS=%0d is illegal (2..8)", NUM_MASTERS);
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic [NUM_MASTERS-1:0] gnt_reg;
  logic [NUM_MASTERS-1:0] ack_reg;
  logic [PTR_W-1:0]       ptr_reg;
  logic [DATA_W-1:0]      rdata_reg;

  logic [NUM_MASTERS-1:0] pick_src;
  logic [NUM_MASTERS-1:0] winner;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       ptr_next;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
  assign pick_src = req;
`else
  logic [NUM_MASTERS-1:0] mask;
  logic [NUM_MASTERS-1:0] masked_req;

  // Masters at or above the pointer get first pick; wrap to the full set if none of them ask.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
    assign mask[gi] = (PTR_W'(gi) >= ptr_reg);
  end
  assign masked_req = req & mask;
  assign pick_src   = (|masked_req) ? masked_req : req;
`endif

  // Isolate the lowest set bit of the candidate set.
  assign winner = pick_src & (~pick_src + NUM_MASTERS'(1));

  // Transposed views so the one-hot grant can select each bit with a plain AND-OR.
  logic [ADDR_W-1:0][NUM_MASTERS-1:0] addr_t;
  logic [DATA_W-1:0][NUM_MASTERS-1:0] wdata_t;
  logic [PTR_W-1:0][NUM_MASTERS-1:0]  idx_t;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    for (genvar gb = 0; gb < ADDR_W; gb++) begin : g_abit
      assign addr_t[gb][gi] = addr[gi*ADDR_W + gb];
    end
    for (genvar gb = 0; gb < DATA_W; gb++) begin : g_dbit
      assign wdata_t[gb][gi] = wdata[gi*DATA_W + gb];
    end
    for (genvar gb = 0; gb < PTR_W; gb++) begin : g_ibit
      assign idx_t[gb][gi] = (((gi >> gb) & 1) != 0);
    end
  end

  for (genvar gb = 0; gb < ADDR_W; gb++) begin : g_sel_addr
    assign sel_addr[gb] = |(addr_t[gb] & gnt_reg);
  end
  for (genvar gb = 0; gb < DATA_W; gb++) begin : g_sel_wdata
    assign sel_wdata[gb] = |(wdata_t[gb] & gnt_reg);
  end
  for (genvar gb = 0; gb < PTR_W; gb++) begin : g_sel_idx
    assign gnt_idx[gb] = |(idx_t[gb] & gnt_reg);
  end
  assign sel_we = |(we & gnt_reg);

  assign ptr_next = (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      ptr_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            gnt_reg   <= winner;
            cnt_reg   <= 4'(WAIT_CYCLES - 1);
            state_reg <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_reg == 4'd0) begin
            if (!sel_we) rdata_reg <= mem_rdata;
            ack_reg   <= gnt_reg;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_DONE: begin
          gnt_reg   <= '0;
          state_reg <= S_IDLE;
`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
          ptr_reg   <= '0;
`else
          ptr_reg   <= ptr_next;
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign ack       = ack_reg;
  assign rdata     = rdata_reg;
  assign busy      = (state_reg != S_IDLE);
  assign mem_en    = (state_reg == S_ACCESS);
  assign mem_wen   = mem_en & sel_we;
  assign mem_addr  = mem_en ? sel_addr : '0;
  assign mem_wdata = mem_en ? sel_wdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random request mixes checked against
// a behavioural arbitration/memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt, ack;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_wen, busy;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];
  int            total = 0;
  int            bad = 0;
  int            ptr_m = 0;
  logic [DW-1:0] rdata_m = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_wen) env_mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: first requester at or after the pointer, wrapping (or lowest index).
  function automatic int pick(input logic [N-1:0] r);
`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic set_master(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".gnt"}, gnt, 0);
    chk({tag, ".ack"}, ack, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_wen"}, mem_wen, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // One transaction: predicts the winner, watches the bus until ack (bounded), updates the model.
  task automatic run_txn(input string tag, input int lat, input int drop_at);
    int w, en_cnt;
    bit done;
    logic [N-1:0] oh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe;
    w = pick(req);
    oh = '0;
    oh[w] = 1'b1;
    ea = addr[w*AW +: AW];
    ed = wdata[w*DW +: DW];
    ewe = we[w];
    en_cnt = 0;
    done = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".mem_wen"}, mem_wen, ewe);
        chk({tag, ".mem_wdata"}, mem_wdata, ed);
        chk({tag, ".gnt"}, gnt, oh);
      end
      if (ack != 0) begin
        done = 1;
        chk({tag, ".ack"}, ack, oh);
        chk({tag, ".gnt_done"}, gnt, oh);
        chk({tag, ".latency"}, cyc, lat);
        chk({tag, ".en_cycles"}, en_cnt, W);
        if (!ewe) rdata_m = ref_mem[ea[7:0]];
        else ref_mem[ea[7:0]] = ed;
        chk({tag, ".rdata"}, rdata, rdata_m);
        ptr_m = (w + 1) % N;
        req[w] = 1'b0;
        $display("txn %s: master=%0d we=%0b addr=%0h wdata=%0h rdata=%0h", tag, w, ewe, ea, ed, rdata);
      end
      if (cyc == drop_at) req[w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i != w) begin
          addr[i*AW +: AW] = $urandom_range(0, 255);
          wdata[i*DW +: DW] = $urandom;
          if (!req[i]) we[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!done) chk({tag, ".ack_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      env_mem[i] <= v;
      ref_mem[i] = v;
    end
    env_mem[8'h10] <= 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single read by master 0.
    set_master(0, 1'b0, 32'h10, 32'h0);
    req = 4'b0001;
    run_txn("read0", W + 1, -1);
    chk("read0.value", rdata, 32'hDEADBEEF);

    // Single write by master 1; rdata must keep the earlier read value.
    @(negedge clk);
    set_master(1, 1'b1, 32'h20, 32'h12345678);
    req = 4'b0010;
    run_txn("write1", W + 1, -1);
    chk("write1.rdata_kept", rdata, 32'hDEADBEEF);
    chk("write1.mem", env_mem[8'h20], 32'h12345678);

    @(negedge clk);
    set_master(2, 1'b0, 32'h20, 32'h0);
    req = 4'b0100;
    run_txn("readback2", W + 1, -1);
    chk("readback2.value", rdata, 32'h12345678);

    // All masters request continuously: service rotates, acks W+2 apart.
    @(negedge clk);
    for (int i = 0; i < N; i++) set_master(i, 1'b0, AW'($urandom_range(0, 255)), $urandom);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      run_txn("rr", (k == 0) ? W + 1 : W + 2, -1);
      req = '1;
    end
    req = '0;

    // Request withdrawn in the middle of ACCESS still completes.
    @(negedge clk);
    @(negedge clk);
    set_master(0, 1'b0, 32'h10, 32'h0);
    req = 4'b0001;
    run_txn("drop", W + 1, 2);
    @(negedge clk);
    chk("drop.busy_after", busy, 0);

    // Reset in the second ACCESS cycle discards the transaction and clears the pointer.
    set_master(0, 1'b0, 32'h10, 32'h0);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.mem_en", mem_en, 1);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    reset = 1'b0;
    ptr_m = 0;
    rdata_m = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid.no_ack", ack, 0);
    end
    set_master(1, 1'b0, AW'($urandom_range(0, 255)), 32'h0);
    req = 4'b0011;
    run_txn("post_rst", W + 1, -1);
    req = '0;

    // Random request mixes, each drained completely.
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      chk("rnd.idle_busy", busy, 0);
      for (int i = 0; i < N; i++)
        set_master(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N && req != 0; k++) run_txn("rnd", (k == 0) ? W + 1 : W + 2, -1);
      if (req != 0) begin
        chk("rnd.drain", req, 0);
        req = '0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised shared-memory bus controller that replaces the fixed two-source tri-state muxing of the single-core datapath (instruction fetch vs. data access).
- Accepts up to NUM_MASTERS requesters (fetch units, load/store units, DMA) with a req/ack handshake.
- Serialises requests onto one memory port with a configurable wait-state count.
- Arbitration is round-robin: no requester starves.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- WAIT_CYCLES, 1: memory access cycles per transaction, 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_MASTERS  per-master request; held high until ack.
- we  input  NUM_MASTERS  per-master write enable (1 = write); stable while req is high.
- addr  input  NUM_MASTERS*ADDR_W  packed addresses; master i occupies [i*ADDR_W +: ADDR_W].
- wdata  input  NUM_MASTERS*DATA_W  packed write data; same packing as addr.
- gnt  output  NUM_MASTERS  one-hot, high for the granted master from the ACCESS state through the DONE state.
- ack  output  NUM_MASTERS  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  registered read data, broadcast to all masters, valid in the ack cycle.
- mem_en  output  1  memory enable.
- mem_wen  output  1  memory write enable (read when 0).
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, sampled on the last ACCESS cycle.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, ACCESS, DONE. State register, wait counter, grant register, priority pointer and rdata are all registered.
- IDLE:
  - If any req is high, select a winner by round-robin.
  - The search starts at the priority pointer and moves upward modulo NUM_MASTERS; the first master with req high wins.
  - Register the winner into gnt, load the wait counter with WAIT_CYCLES-1, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_en=1.
  - mem_wen, mem_addr and mem_wdata are taken from the granted master's we/addr/wdata slices (combinational select by gnt).
  - The counter decrements each cycle.
  - On the cycle where the counter is 0:
    - if mem_wen=0, capture mem_rdata into rdata;
    - go to DONE.
- DONE:
  - ack[g]=1 for exactly one cycle; gnt stays held; mem_en=0.
  - Priority pointer <= (g+1) mod NUM_MASTERS.
  - Next state is always IDLE.
- Latency: a request seen in IDLE at cycle 0 gives mem_en high in cycles 1..WAIT_CYCLES and ack in cycle WAIT_CYCLES+1. Minimum spacing between transactions is WAIT_CYCLES+2 cycles.
- Outside ACCESS: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- After a write, rdata keeps its previous value.
- Masters must deassert req on the clock edge that ends the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- Req dropped mid-transaction: the transaction still completes and ack still pulses. No abort.
- Simultaneous requests: exactly one grant; the others wait. A waiting master is served within NUM_MASTERS transactions.
- Inputs of non-granted masters may change freely without affecting the bus.
- Reset (at any time, including mid-ACCESS):
  - next cycle: state=IDLE; gnt=0, ack=0, busy=0, rdata=0, all mem_* outputs=0;
  - priority pointer=0, wait counter=0;
  - an in-flight transaction is discarded and no ack is issued.
- Counter width is 4 bits. WAIT_CYCLES=0 or >15 is illegal (simulation error message).

Optional Feature:
- Macro: MEM_BUS_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index requesting master always wins (master 0 = instruction fetch). The priority pointer is not implemented and is held at 0.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset then single read: NUM_MASTERS=2, WAIT_CYCLES=1. req[0]=1, we=0, addr0=0x10, memory at 0x10 = 0xDEADBEEF -> mem_en in cycle 1 with mem_addr=0x10; ack[0] in cycle 2; rdata=0xDEADBEEF.
- Single write, WAIT_CYCLES=3: req[1]=1, we[1]=1, addr1=0x20, wdata1=0x12345678 -> mem_en=mem_wen=1 for 3 cycles with those addr/data; ack[1] at cycle 4; memory 0x20 reads back 0x12345678.
- Round-robin: NUM_MASTERS=4, all req held high continuously -> acks in order 0,1,2,3,0, each WAIT_CYCLES+2 cycles apart. With FIXED_PRIO_EN defined -> every ack goes to master 0.
- Req drop mid-access: req[0] deasserted during ACCESS -> ack[0] still pulses once; the bus returns to IDLE.
- Reset mid-ACCESS with WAIT_CYCLES=4: assert reset in the second ACCESS cycle -> next cycle all outputs 0, no ack pulse. A subsequent req from master 1 while master 0 also requests -> grant goes to master 0 (pointer reset to 0).
- Isolation: vary addr/wdata/we of non-granted masters every cycle during a transaction -> mem_addr/mem_wdata/mem_wen stay equal to the granted master's values.
